// File: rtl/mult_pkg.sv
// mult_pkg: shared state encodings, Booth op codes and default width
// for the shared Booth multiplier.
package mult_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {NOP = 2'd0, ADD = 2'd1, SUB = 2'd2} booth_op_t;

    function automatic booth_op_t booth_op(input logic [1:0] pair);
        return pair == 2'b01 ? ADD : pair == 2'b10 ? SUB : NOP;
    endfunction

endpackage

// File: rtl/booth_step_core.sv
// booth_step_core: iterative radix-2 Booth datapath, one step per enabled cycle.
// The WIDTH+1-bit accumulator keeps the most negative multiplicand exact.
module booth_step_core
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   acc, m, sum;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [CW-1:0]    count;
    booth_op_t        op;

    always_comb begin
        op  = booth_op({q[0], q_1});
        sum = op == ADD ? acc + m : op == SUB ? acc - m : acc;
    end

    assign last     = count == CW'(WIDTH - 1);
    assign product  = {acc[WIDTH-1:0], q};
    assign overflow = !(&product[2*WIDTH-1:WIDTH-1] || ~|product[2*WIDTH-1:WIDTH-1]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
        end else if (load) begin
            acc   <= '0;
            m     <= {a[WIDTH-1], a};
            q     <= b;
            q_1   <= 1'b0;
            count <= '0;
        end else if (step) begin
            // arithmetic shift of {acc, q, q_1} after the add/sub
            acc   <= {sum[WIDTH], sum[WIDTH:1]};
            q     <= {sum[0], q[WIDTH-1:1]};
            q_1   <= q[0];
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin sharing of one Booth multiplier between
// NREQ requesters, returning tagged products over a valid/ready response.
module booth_mult_arbiter
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [2*WIDTH-1:0]    resp_result,
    output logic                  resp_overflow,
    output logic                  busy
);
    state_t             state;
    logic [IDW-1:0]     rr, gnt_id, idx;
    logic               gnt_any, last, ovf;
    logic [2*WIDTH-1:0] product;

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr) + k) % NREQ);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
        req_ready = (state == IDLE && gnt_any) ? NREQ'(1) << gnt_id : '0;
    end

    booth_step_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (state == IDLE && gnt_any),
        .step     (state == BUSY),
        .a        (req_a[gnt_id*WIDTH +: WIDTH]),
        .b        (req_b[gnt_id*WIDTH +: WIDTH]),
        .last     (last),
        .product  (product),
        .overflow (ovf)
    );

    assign resp_result   = resp_valid ? product : '0;
    assign resp_overflow = resp_valid & ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr         <= '0;
            resp_id    <= '0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gnt_any) begin
                    state   <= BUSY;
                    busy    <= 1'b1;
                    resp_id <= gnt_id;
                    rr      <= gnt_id == IDW'(NREQ - 1) ? '0 : gnt_id + IDW'(1);
                end
                BUSY: if (last) begin
                    state      <= DONE;
                    resp_valid <= 1'b1;
                end
                DONE: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: table-driven and sequence checks of the shared
// Booth multiplier with a response scoreboard.
module tb_booth_mult_arbiter;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b1;
    logic [IW-1:0]    resp_id;
    logic [2*W-1:0]   resp_result;
    logic             resp_overflow;
    logic             busy;

    typedef struct {
        int             id;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
        logic           ovf;
    } vec_t;

    typedef struct {
        int             id;
        logic [2*W-1:0] res;
        logic           ovf;
    } exp_t;

    exp_t exp_tab[N];
    exp_t sb[$];
    int   got_ids[$];
    vec_t vecs[8];
    int   n_chk = 0, n_fail = 0, n_resp = 0, cyc = 0, acc_cyc = 0;
    logic prev_rv = 1'b0;

    booth_mult_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_result   (resp_result),
        .resp_overflow (resp_overflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // accepts and responses complete on the posedge following this negedge
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            prev_rv = 1'b0;
        end else begin
            if (|(req_ready & req_valid)) begin
                chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
                for (int i = 0; i < N; i++)
                    if (req_ready[i] && req_valid[i]) sb.push_back(exp_tab[i]);
                acc_cyc = cyc + 1;
            end
            if (resp_valid && !prev_rv) chk("latency", 64'(cyc - acc_cyc), 64'd32);
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_resp: id %0d result %h with nothing outstanding", resp_id, resp_result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_id", 64'(resp_id), 64'(e.id));
                    chk("resp_result", resp_result, e.res);
                    chk("resp_overflow", 64'(resp_overflow), 64'(e.ovf));
                end
                got_ids.push_back(int'(resp_id));
                n_resp++;
            end
            prev_rv = resp_valid;
        end
    end

    task automatic post(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] res, input logic ovf);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        exp_tab[id].id  = id;
        exp_tab[id].res = res;
        exp_tab[id].ovf = ovf;
        req_valid[id] = 1'b1;
    endtask

    task automatic wait_accept(input int id);
        int b = 0;
        while (b < 100 && !(req_ready[id] && req_valid[id])) begin
            @(negedge clk);
            b++;
        end
        if (b >= 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: requester %0d never granted", id);
        end
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic drain(input int target);
        int budget = 0;
        logic [N-1:0] g;
        while (n_resp < target && budget < 500) begin
            @(negedge clk);
            g = req_ready & req_valid;
            @(posedge clk);
            #1 req_valid = req_valid & ~g;
            budget++;
        end
        if (n_resp < target) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: responses %0d required %0d", n_resp, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, r0, b, t_xfer;
        vecs[0] = '{0, 32'd5,         32'hFFFFFFF9, 64'hFFFFFFFF_FFFFFFDD, 1'b0};
        vecs[1] = '{1, 32'h80000000,  32'hFFFFFFFF, 64'h00000000_80000000, 1'b1};
        vecs[2] = '{2, 32'h80000000,  32'h80000000, 64'h40000000_00000000, 1'b1};
        vecs[3] = '{3, 32'd11,        32'd0,        64'd0,                 1'b0};
        vecs[4] = '{0, 32'd10,        32'd1,        64'd10,                1'b0};
        vecs[5] = '{1, 32'hFFFFFFFF,  32'hFFFFFFF9, 64'd7,                 1'b0};
        vecs[6] = '{2, 32'h7FFFFFFF,  32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 1'b1};
        vecs[7] = '{3, 32'hFFFF0000,  32'h00008000, 64'hFFFFFFFF_80000000, 1'b0};

        #3;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_result", resp_result, 64'd0);
        chk("rst_resp_overflow", 64'(resp_overflow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // round robin from reset, then requester 0 again after 3
        post(0, 32'd2, 32'd3, 64'd6, 1'b0);
        post(1, 32'hFFFFFFF4, 32'hFFFFFFFC, 64'd48, 1'b0);
        post(2, 32'hFFFFFFF7, 32'd5, 64'hFFFFFFFF_FFFFFFD3, 1'b0);
        post(3, 32'd4, 32'd6, 64'd24, 1'b0);
        base = got_ids.size();
        r0 = n_resp;
        drain(r0 + 1);
        post(0, 32'd7, 32'd8, 64'd56, 1'b0);
        drain(r0 + 5);
        for (int k = 0; k < 5; k++)
            chk("rr_order", 64'(got_ids.size() > base + k ? got_ids[base + k] : -1), 64'(k == 4 ? 0 : k));

        for (int i = 0; i < 8; i++) begin
            post(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf);
            drain(n_resp + 1);
        end

        // backpressure in DONE with another requester waiting
        resp_ready = 1'b0;
        post(0, 32'hFFFFFFFD, 32'd4, 64'hFFFFFFFF_FFFFFFF4, 1'b0);
        wait_accept(0);
        post(2, 32'd6, 32'd7, 64'd42, 1'b0);
        b = 0;
        while (b < 100 && !resp_valid) begin
            @(negedge clk);
            b++;
        end
        chk("bp_valid_rise", 64'(resp_valid), 64'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_result", resp_result, 64'hFFFFFFFF_FFFFFFF4);
            chk("bp_id", 64'(resp_id), 64'd0);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        t_xfer = cyc;
        chk("bp_released_valid", 64'(resp_valid), 64'd0);
        chk("bp_next_ready", 64'(req_ready), 64'b0100);
        resp_ready = 1'b1;
        drain(n_resp + 1);
        chk("bp_accept_edge", 64'(acc_cyc), 64'(t_xfer + 1));

        // late requests while serving requester 1: pointer 2 favours 3 over 0
        base = got_ids.size();
        r0 = n_resp;
        post(1, 32'd6, 32'hFFFFFFFB, 64'hFFFFFFFF_FFFFFFE2, 1'b0);
        wait_accept(1);
        @(negedge clk);
        post(3, 32'd3, 32'd3, 64'd9, 1'b0);
        post(0, 32'hFFFFFFFE, 32'd8, 64'hFFFFFFFF_FFFFFFF0, 1'b0);
        repeat (3) @(negedge clk);
        chk("late_ready_busy", 64'(req_ready), 64'd0);
        chk("late_busy", 64'(busy), 64'd1);
        drain(r0 + 3);
        chk("late_order0", 64'(got_ids.size() > base ? got_ids[base] : -1), 64'd1);
        chk("late_order1", 64'(got_ids.size() > base + 1 ? got_ids[base + 1] : -1), 64'd3);
        chk("late_order2", 64'(got_ids.size() > base + 2 ? got_ids[base + 2] : -1), 64'd0);

        // reset in the middle of a multiply
        post(1, 32'd7, 32'd9, 64'd63, 1'b0);
        wait_accept(1);
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_id", 64'(resp_id), 64'd0);
        chk("mid_rst_result", resp_result, 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        r0 = n_resp;
        repeat (40) @(negedge clk);
        chk("mid_rst_no_resp", 64'(n_resp), 64'(r0));
        base = got_ids.size();
        post(2, 32'd4, 32'd5, 64'd20, 1'b0);
        post(0, 32'd2, 32'd3, 64'd6, 1'b0);
        drain(r0 + 2);
        chk("post_rst_first", 64'(got_ids.size() > base ? got_ids[base] : -1), 64'd0);
        chk("post_rst_second", 64'(got_ids.size() > base + 1 ? got_ids[base + 1] : -1), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
